// File: rtl/pixel_row_loader_pkg.sv
// Shared state encoding and default geometry for the pixel row loader.
package pixel_row_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_NR_OF_BITS     = 28;
    localparam int DEF_NR_OF_ROWS     = 28;
    localparam int DEF_ROW_ADDR_BITS  = 5;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_row_loader_shift.sv
// Serial-in/parallel-out pixel shift register. Only the NrOfBits-1 older
// pixels are stored; the parallel word presents them together with the
// pixel arriving this cycle, so the loader can latch a completed row on the
// same edge that accepts its last pixel.
module pixel_shift_reg #(
    parameter int NrOfBits = 28
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                shift_en,
    input  logic                din,
    output logic [NrOfBits-1:0] word
);

    logic [NrOfBits-2:0] hist;

    assign word = {hist, din};

    // Shift the new pixel in at the LSB; clear at frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
        end else if (clr) begin
            hist <= '0;
        end else if (shift_en) begin
            hist <= word[NrOfBits-2:0];
        end
    end

endmodule

// File: rtl/pixel_row_loader.sv
// Packs a serial binarised pixel stream into row words and writes them, one
// strobe per row, into the bitmap register bank. All advancement is gated
// by Tick so the loader stays in lockstep with the register bank.
module pixel_row_loader
    import pixel_row_loader_pkg::*;
#(
    parameter int NrOfBits    = DEF_NR_OF_BITS,
    parameter int NrOfRows    = DEF_NR_OF_ROWS,
    parameter int RowAddrBits = DEF_ROW_ADDR_BITS
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Tick,
    input  logic                   start,
    input  logic                   pix_valid,
    input  logic                   pix_bit,
    output logic                   pix_ready,
    output logic [NrOfBits-1:0]    D,
    output logic                   ClockEnable,
    output logic [RowAddrBits-1:0] row_addr,
    output logic                   busy,
    output logic                   done
);

    localparam int CntW = cnt_width(NrOfBits);
    localparam logic [CntW-1:0]        LastBit = CntW'(NrOfBits - 1);
    localparam logic [RowAddrBits-1:0] LastRow = RowAddrBits'(NrOfRows - 1);

    state_t                 state, state_nxt;
    logic [CntW-1:0]        bit_cnt;
    logic [RowAddrBits-1:0] row_cnt;
    logic [NrOfBits-1:0]    word;
    logic                   accept;
    logic                   last_bit;
    logic                   frame_go;

    assign pix_ready   = (state == SHIFT);
    assign ClockEnable = (state == COMMIT);
    assign busy        = (state == SHIFT) || (state == COMMIT);
    assign done        = (state == DONE);
    // The row counter parks on the last row; outside a load the address reads 0.
    assign row_addr    = busy ? row_cnt : '0;

    assign accept   = pix_valid & pix_ready & Tick;
    assign last_bit = (bit_cnt == LastBit);
    assign frame_go = Tick & start & (state == IDLE);

    pixel_shift_reg #(.NrOfBits(NrOfBits)) u_shreg (
        .clk      (Clock),
        .rst      (Reset),
        .clr      (frame_go),
        .shift_en (accept),
        .din      (pix_bit),
        .word     (word)
    );

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; nothing moves without Tick.
    always_comb begin
        state_nxt = state;
        if (Tick) begin
            case (state)
                IDLE:    if (start) state_nxt = SHIFT;
                SHIFT:   if (accept && last_bit) state_nxt = COMMIT;
                COMMIT:  state_nxt = (row_cnt == LastRow) ? DONE : SHIFT;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Bit and row counters; both saturate rather than wrap.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bit_cnt <= '0;
            row_cnt <= '0;
        end else if (Tick) begin
            case (state)
                IDLE: if (start) begin
                    bit_cnt <= '0;
                    row_cnt <= '0;
                end
                SHIFT: if (accept && !last_bit) bit_cnt <= bit_cnt + CntW'(1);
                COMMIT: begin
                    bit_cnt <= '0;
                    if (row_cnt != LastRow) row_cnt <= row_cnt + RowAddrBits'(1);
                end
                default: ;
            endcase
        end
    end

    // Latch the completed row on the edge that accepts its last pixel; held until the next row.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                 D <= '0;
        else if (accept && last_bit) D <= word;
    end

endmodule
